img_buffer: RTL

IMG_BUFFER -- requirements
Module: img_buffer

---
 rtl/img_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/img_buffer.sv
// -----------------------------------------------------------------------------
// img_buffer
//   Collects bytes from a serial receiver into one image frame of NUM_BYTES
//   bytes. The assembled frame goes to the inference block.
//   A partial frame is dropped (with a one-cycle frame_error pulse) if the
//   sender goes quiet for too long.
//
// Parameters
//   NUM_BYTES       bytes per frame (default 113 -> 904 image bits)
//   TIMEOUT_CYCLES  longest allowed idle gap inside a partial frame (2..65535)
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   rx_byte          incoming byte; rx_byte[0] lands at the lowest bit of its slot
//   rx_valid         rx_byte is valid this cycle
//   rx_ready         block can take a byte this cycle (low only when FULL)
//   buffer_clear     consumer discards the frame; wins over a same-cycle byte
//   img_out          assembled frame, byte k at bits [8k+7:8k]
//   img_buffer_full  img_out holds a complete frame
//   byte_count       bytes accepted in the current frame
//   frame_error      one-cycle pulse when a partial frame times out
// -----------------------------------------------------------------------------
module img_buffer #(
    parameter int NUM_BYTES      = 113,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   buffer_clear,
    output logic [NUM_BYTES*8-1:0] img_out,
    output logic                   img_buffer_full,
    output logic [6:0]             byte_count,
    output logic                   frame_error
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    // Idle counter value on the cycle the partial frame is abandoned.
    localparam logic [15:0] IDLE_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]  COUNT_LAST = 7'(NUM_BYTES - 1);

    state_t                 state_r;
    logic [NUM_BYTES*8-1:0] img_r;
    logic [6:0]             byte_count_r;
    logic                   full_r;
    logic                   frame_error_r;
    logic [15:0]            idle_r;

    logic                   ready_s;
    logic                   accept_s;
    logic                   last_byte_s;
    logic                   timeout_s;
    logic [9:0]             bit_idx_s;

    // Handshake decode and write-slot selection.
    always_comb begin
        ready_s     = 1'b0;
        accept_s    = 1'b0;
        last_byte_s = 1'b0;
        timeout_s   = 1'b0;
        bit_idx_s   = {byte_count_r, 3'b000};
        if (state_r != ST_FULL) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        // A clear in the same cycle discards the byte rather than storing it.
        if (rx_valid && ready_s && !buffer_clear) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (byte_count_r == COUNT_LAST) begin
            last_byte_s = 1'b1;
        end else begin
            last_byte_s = 1'b0;
        end
        // An accept in the expiry cycle keeps the frame alive.
        if ((state_r == ST_FILLING) && (idle_r == IDLE_LAST) && !accept_s) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Frame FSM with its datapath, idle counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_EMPTY;
            img_r         <= '0;
            byte_count_r  <= 7'd0;
            full_r        <= 1'b0;
            frame_error_r <= 1'b0;
            idle_r        <= 16'd0;
        end else begin
            frame_error_r <= 1'b0;
            if (buffer_clear) begin
                state_r      <= ST_EMPTY;
                img_r        <= '0;
                byte_count_r <= 7'd0;
                full_r       <= 1'b0;
                idle_r       <= 16'd0;
            end else if (accept_s) begin
                img_r[bit_idx_s +: 8] <= rx_byte;
                byte_count_r          <= byte_count_r + 7'd1;
                idle_r                <= 16'd0;
                if (last_byte_s) begin
                    state_r <= ST_FULL;
                    full_r  <= 1'b1;
                end else begin
                    state_r <= ST_FILLING;
                end
            end else if (timeout_s) begin
                state_r       <= ST_EMPTY;
                img_r         <= '0;
                byte_count_r  <= 7'd0;
                idle_r        <= 16'd0;
                frame_error_r <= 1'b1;
            end else begin
                case (state_r)
                    ST_FILLING: idle_r <= idle_r + 16'd1;
                    ST_EMPTY:   idle_r <= 16'd0;
                    ST_FULL:    idle_r <= 16'd0;
                    default: begin
                        // Unreachable encoding: fall back to a clean empty buffer.
                        state_r      <= ST_EMPTY;
                        img_r        <= '0;
                        byte_count_r <= 7'd0;
                        full_r       <= 1'b0;
                        idle_r       <= 16'd0;
                    end
                endcase
            end
        end
    end

    assign rx_ready        = ready_s;
    assign img_out         = img_r;
    assign img_buffer_full = full_r;
    assign byte_count      = byte_count_r;
    assign frame_error     = frame_error_r;

endmodule
